sent_rx_nibble_decoder: RTL
===========================

// Module: sent_rx_nibble_decoder
// PURPOSE
//  Front end of the SENT receive path: converts the raw data_pulse line from sent_tx_pulse_gen into decoded nibbles.
//  Measures falling-edge-to-falling-edge intervals in ticks, locks on the 56-tick sync pulse, and decodes
//  status / data / CRC nibbles (value = ticks - 12). Detects the optional pause pulse.
//  Feeds nibble-assembly and CRC-check logic; all timing is in the clk domain.
// PARAMETERS
//  TICK_CLKS  3   clk cycles per SENT tick (>=2)
//  NIBBLES    6   data nibbles per frame (1..6); frame = status + NIBBLES + CRC
//  PAUSE_EN   1   1: accept pause pulse (12..768 ticks) after CRC nibble; 0: pause is an error
// PORTS
//  clk           in   1  receive clock
//  reset         in   1  synchronous, active-high reset
//  data_pulse    in   1  SENT line, already synchronous to clk
//  nibble        out  4  decoded nibble value
//  nibble_valid  out  1  1-cycle strobe: nibble/nibble_idx valid
//  nibble_idx    out  3  0 = status, 1..NIBBLES = data, NIBBLES+1 = CRC
//  sync_det      out  1  1-cycle strobe: 56-tick sync accepted
//  pause_det     out  1  1-cycle strobe: pause pulse accepted
//  frame_done    out  1  1-cycle strobe, same cycle as CRC nibble_valid
//  err_len       out  1  1-cycle strobe: illegal interval or timeout; decoder drops lock
//  locked        out  1  level: in a frame (between sync_det and frame end/error)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters 0; sampled line register = 1.
//  - Edge detect: d1 <= data_pulse, d2 <= d1; fall = d2 & ~d1. Interval = clk cycles between consecutive falls.
//  - Tick count: prescaler 0..TICK_CLKS-1, tick counter increments on prescaler wrap; both cleared on fall.
//    Interval ticks T = tick_cnt + (prescaler >= TICK_CLKS/2), i.e. rounded to nearest tick.
//  - Tick counter is 10 bits, saturates at 1023; T > 768 while waiting => timeout -> err_len, state WAIT_SYNC.
//  - All strobes are registered: asserted the cycle after fall is detected, for exactly 1 cycle.
//  - States:
//    IDLE: first fall -> WAIT_SYNC (no strobe; interval not yet measurable).
//    WAIT_SYNC: on fall, T==56 -> sync_det, locked=1, idx=0, -> DATA; any other T ignored (no err_len).
//    DATA: on fall, 12<=T<=27 -> nibble=T-12, nibble_valid, nibble_idx=idx, idx++;
//      if idx was NIBBLES+1 also frame_done, locked=0, -> POST_CRC.
//      T==56 mid-frame -> err_len then treated as new sync (sync_det next... same cycle allowed both), idx=0, stay DATA.
//      other T -> err_len, locked=0, -> WAIT_SYNC.
//    POST_CRC: on fall, T==56 -> sync_det, locked=1, idx=0, -> DATA;
//      PAUSE_EN & 12<=T<=768 & T!=56 -> pause_det, -> WAIT_SYNC; else err_len, -> WAIT_SYNC.
//  - Interval of a sync pulse is 56 exactly after rounding; 55/57 rejected.
//  - Line stuck (no fall): timeout applies in DATA and POST_CRC only when counter passes 768 (err_len once, then WAIT_SYNC).
//  - Reset asserted mid-frame: next cycle all outputs 0, state IDLE; partial frame discarded.
//  - nibble/nibble_idx hold last value between strobes (not cleared).
// TESTING
//  (TICK_CLKS=3, NIBBLES=6, PAUSE_EN=1)
//  1. Reset, then 168-clk sync, then intervals 36,45,81,57,36,48,39,69 clk -> sync_det; nibbles 0,3,F,7,0,4,1,B idx 0..7; frame_done with idx 7.
//  2. After frame of test 1, pause of 300 ticks then sync -> pause_det, then sync_det, second frame decodes identically.
//  3. Mid-frame interval of 30 ticks (90 clk) -> err_len, locked=0, no nibble_valid; next 56-tick sync relocks.
//  4. Sync of 55 ticks (165 clk) and 57 ticks (171 clk) -> no sync_det; 167 clk (rounds to 56) -> sync_det.
//  5. Line held high 2400 clk in DATA -> single err_len, locked=0; state WAIT_SYNC.
//  6. Assert reset during nibble 3 -> next cycle all outputs 0; following sync decodes a full clean frame.

Source files
------------

// File: rtl/sent_rx_nibble_decoder.sv
// SENT receive front end: measures fall-to-fall intervals in ticks, locks on the
// 56-tick sync pulse and decodes status/data/CRC nibbles plus the optional pause pulse.
module sent_rx_nibble_decoder #(
    parameter int unsigned TICK_CLKS = 3,
    parameter int unsigned NIBBLES   = 6,
    parameter int unsigned PAUSE_EN  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_pulse,
    output logic [3:0] nibble,
    output logic       nibble_valid,
    output logic [2:0] nibble_idx,
    output logic       sync_det,
    output logic       pause_det,
    output logic       frame_done,
    output logic       err_len,
    output logic       locked
);

    localparam int unsigned     PW    = (TICK_CLKS > 2) ? $clog2(TICK_CLKS) : 1;
    localparam logic [PW-1:0]   PMAX  = PW'(TICK_CLKS - 1);
    localparam logic [PW-1:0]   PHALF = PW'(TICK_CLKS / 2);
    localparam logic [2:0]      CRC_IDX = 3'(NIBBLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, DATA, POST_CRC} state_t;

    state_t        r_state;
    logic          r_d1;
    logic          r_d2;
    logic [PW-1:0] r_pre;
    logic [9:0]    r_tick;
    logic [2:0]    r_idx;

    logic          w_fall;
    logic [10:0]   w_t;
    logic          w_is_sync;
    logic          w_is_nib;
    logic          w_is_pause;
    logic          w_timeout;

    always_comb begin
        w_fall     = r_d2 & ~r_d1;
        // Round the interval to the nearest tick using the prescaler phase.
        w_t        = {1'b0, r_tick} + {10'd0, (r_pre >= PHALF)};
        w_is_sync  = (w_t == 11'd56);
        w_is_nib   = (w_t >= 11'd12) && (w_t <= 11'd27);
        w_is_pause = (PAUSE_EN != 0) && (w_t >= 11'd12) && (w_t <= 11'd768);
        w_timeout  = (w_t > 11'd768);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d1   <= 1'b1;
            r_d2   <= 1'b1;
            r_pre  <= '0;
            r_tick <= '0;
        end else begin
            r_d1 <= data_pulse;
            r_d2 <= r_d1;
            if (w_fall) begin
                r_pre  <= '0;
                r_tick <= '0;
            end else if (r_pre == PMAX) begin
                r_pre <= '0;
                if (r_tick != 10'd1023) begin
                    r_tick <= r_tick + 10'd1;
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            nibble       <= '0;
            nibble_valid <= 1'b0;
            nibble_idx   <= '0;
            sync_det     <= 1'b0;
            pause_det    <= 1'b0;
            frame_done   <= 1'b0;
            err_len      <= 1'b0;
            locked       <= 1'b0;
        end else begin
            nibble_valid <= 1'b0;
            sync_det     <= 1'b0;
            pause_det    <= 1'b0;
            frame_done   <= 1'b0;
            err_len      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= WAIT_SYNC;
                    end
                end
                WAIT_SYNC: begin
                    if (w_fall && w_is_sync) begin
                        sync_det <= 1'b1;
                        locked   <= 1'b1;
                        r_idx    <= '0;
                        r_state  <= DATA;
                    end
                end
                DATA: begin
                    if (w_fall) begin
                        if (w_is_nib) begin
                            nibble       <= 4'(w_t - 11'd12);
                            nibble_valid <= 1'b1;
                            nibble_idx   <= r_idx;
                            r_idx        <= r_idx + 3'd1;
                            if (r_idx == CRC_IDX) begin
                                frame_done <= 1'b1;
                                locked     <= 1'b0;
                                r_state    <= POST_CRC;
                            end
                        end else if (w_is_sync) begin
                            // Unexpected sync mid-frame: flag it, then relock on it.
                            err_len  <= 1'b1;
                            sync_det <= 1'b1;
                            r_idx    <= '0;
                        end else begin
                            err_len <= 1'b1;
                            locked  <= 1'b0;
                            r_state <= WAIT_SYNC;
                        end
                    end else if (w_timeout) begin
                        err_len <= 1'b1;
                        locked  <= 1'b0;
                        r_state <= WAIT_SYNC;
                    end
                end
                POST_CRC: begin
                    if (w_fall) begin
                        if (w_is_sync) begin
                            sync_det <= 1'b1;
                            locked   <= 1'b1;
                            r_idx    <= '0;
                            r_state  <= DATA;
                        end else if (w_is_pause) begin
                            pause_det <= 1'b1;
                            r_state   <= WAIT_SYNC;
                        end else begin
                            err_len <= 1'b1;
                            r_state <= WAIT_SYNC;
                        end
                    end else if (w_timeout) begin
                        err_len <= 1'b1;
                        r_state <= WAIT_SYNC;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
